// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the registered output bundle
// shared by the VGA sync controller.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned DEF_H_TOTAL =
      DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL =
      DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int unsigned DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       display;
    logic [9:0] x;
    logic [9:0] y;
    logic       pixel_tick;
    logic       line_start;
    logic       frame_start;
  } vga_out_t;

  localparam vga_out_t VGA_OUT_RESET = '{
    hsync: 1'b1, vsync: 1'b1, display: 1'b0, x: 10'd0, y: 10'd0,
    pixel_tick: 1'b0, line_start: 1'b0, frame_start: 1'b0
  };

endpackage

// File: rtl/vga_tick_gen.sv
// Pixel-rate divider: pulses o_tick once every CLK_DIV clocks while enabled,
// restarting from zero whenever enable is low.
module vga_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_enable,
  output logic o_tick
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div <= '0;
    end else if (!i_enable || (r_div == LAST)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_tick = i_enable && (r_div == LAST);

endmodule

// File: rtl/vga_sync_controller.sv
// VGA timing generator: pixel/line counters plus a registered output stage
// carrying syncs, position, display window and position-advance pulses.
module vga_sync_controller
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       display,
  output logic       pixelTick,
  output logic       lineStart,
  output logic       frameStart
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       w_tick;
  logic [9:0] r_hcount;
  logic [9:0] r_vcount;
  logic       r_run;
  logic       r_adv;
  vga_out_t   w_out_d;
  vga_out_t   r_out;

  vga_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rstn    (rstn),
    .i_enable(enable),
    .o_tick  (w_tick)
  );

  // r_run is low until the first tick after reset/enable; that tick lands on
  // (0,0) instead of advancing, so every start produces a frameStart.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_run    <= 1'b0;
      r_adv    <= 1'b0;
    end else if (!enable) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_run    <= 1'b0;
      r_adv    <= 1'b0;
    end else begin
      r_adv <= w_tick;
      if (w_tick) begin
        if (!r_run) begin
          r_run <= 1'b1;
        end else if (r_hcount == H_LAST) begin
          r_hcount <= '0;
          r_vcount <= (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
        end else begin
          r_hcount <= r_hcount + 10'd1;
        end
      end
    end
  end

  always_comb begin
    w_out_d = VGA_OUT_RESET;
    if (r_run) begin
      w_out_d.hsync       = !((r_hcount >= H_SS) && (r_hcount <= H_SE));
      w_out_d.vsync       = !((r_vcount >= V_SS) && (r_vcount <= V_SE));
      w_out_d.display     = (r_hcount < H_VIS) && (r_vcount < V_VIS);
      w_out_d.x           = r_hcount;
      w_out_d.y           = r_vcount;
      w_out_d.pixel_tick  = r_adv;
      w_out_d.line_start  = r_adv && (r_hcount == 10'd0);
      w_out_d.frame_start = r_adv && (r_hcount == 10'd0) && (r_vcount == 10'd0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out <= VGA_OUT_RESET;
    end else begin
      r_out <= w_out_d;
    end
  end

  assign hsync      = r_out.hsync;
  assign vsync      = r_out.vsync;
  assign display    = r_out.display;
  assign x          = r_out.x;
  assign y          = r_out.y;
  assign pixelTick  = r_out.pixel_tick;
  assign lineStart  = r_out.line_start;
  assign frameStart = r_out.frame_start;

endmodule

// File: tb/tb_vga_sync_controller.sv
// Bench for vga_sync_controller: small-timing builds at CLK_DIV=4 and 1 checked
// cycle by cycle against an analytic model, plus a default-timing build.
module tb_vga_sync_controller;

  localparam int HV = 8, HF = 2, HS = 3, HB = 3, HT = 16;
  localparam int VV = 4, VF = 1, VS = 2, VB = 2, VT = 9;
  localparam int HSS = HV + HF, HSE = HV + HF + HS - 1;
  localparam int VSS = VV + VF, VSE = VV + VF + VS - 1;
  localparam int FRAME4 = HT * VT * 4;
  localparam int FRAME1 = HT * VT;

  typedef logic [25:0] obs_t;
  localparam obs_t RST = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 3'b000};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b1;
  always #5 clk = ~clk;

  logic       hs4, vs4, d4, pt4, ls4, fs4;
  logic [9:0] x4, y4;
  logic       hs1, vs1, d1, pt1, ls1, fs1;
  logic [9:0] x1, y1;
  logic       hsd, vsd, dd, ptd, lsd, fsd;
  logic [9:0] xd, yd;
  obs_t       a4, a1, ad;

  assign a4 = {hs4, vs4, d4, x4, y4, pt4, ls4, fs4};
  assign a1 = {hs1, vs1, d1, x1, y1, pt1, ls1, fs1};
  assign ad = {hsd, vsd, dd, xd, yd, ptd, lsd, fsd};

  vga_sync_controller #(
    .CLK_DIV(4), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut4 (
    .clk(clk), .rstn(rstn), .enable(enable), .hsync(hs4), .vsync(vs4), .x(x4), .y(y4),
    .display(d4), .pixelTick(pt4), .lineStart(ls4), .frameStart(fs4)
  );

  vga_sync_controller #(
    .CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut1 (
    .clk(clk), .rstn(rstn), .enable(enable), .hsync(hs1), .vsync(vs1), .x(x1), .y(y1),
    .display(d1), .pixelTick(pt1), .lineStart(ls1), .frameStart(fs1)
  );

  vga_sync_controller dutd (
    .clk(clk), .rstn(rstn), .enable(enable), .hsync(hsd), .vsync(vsd), .x(xd), .y(yd),
    .display(dd), .pixelTick(ptd), .lineStart(lsd), .frameStart(fsd)
  );

  int n_checks = 0;
  int n_fail = 0;
  obs_t q4[$];
  obs_t q1[$];
  int fs4_k[$];
  int fs1_k[$];
  int ls_in_f, disp_in_f, vs_low_in_f;

  // Expected outputs k clock edges after reset/enable release: position p is
  // shown from edge div*(p+1)+1 for div clocks, pixelTick on its first clock.
  function automatic obs_t model(input int k, input int div);
    int m, pos, h, v;
    logic pt;
    if (k <= div) return RST;
    m   = (k - 1) / div;
    pos = m - 1;
    pt  = ((k - 1) % div) == 0;
    h   = pos % HT;
    v   = (pos / HT) % VT;
    return {!(h >= HSS && h <= HSE), !(v >= VSS && v <= VSE), (h < HV && v < VV),
            10'(h), 10'(v), pt, pt && (h == 0), pt && (h == 0) && (v == 0)};
  endfunction

  task automatic run_sb(input int n, input int k0);
    obs_t e4, e1;
    for (int k = k0; k < k0 + n; k++) begin
      q4.push_back(model(k, 4));
      q1.push_back(model(k, 1));
      @(posedge clk);
      #1;
      e4 = q4.pop_front();
      e1 = q1.pop_front();
      n_checks++;
      if (a4 !== e4) begin
        n_fail++;
        $display("FAIL sb_div4 k=%0d actual=%h required=%h", k, a4, e4);
      end
      n_checks++;
      if (a1 !== e1) begin
        n_fail++;
        $display("FAIL sb_div1 k=%0d actual=%h required=%h", k, a1, e1);
      end
      if (fs4) fs4_k.push_back(k);
      if (fs1) fs1_k.push_back(k);
      if (fs4_k.size() == 1) begin
        if (ls4) ls_in_f++;
        if (pt4 && d4) disp_in_f++;
        if (!vs4) vs_low_in_f++;
      end
    end
  endtask

  task automatic clear_stats();
    fs4_k.delete();
    fs1_k.delete();
    ls_in_f = 0;
    disp_in_f = 0;
    vs_low_in_f = 0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (a4 !== RST) begin
      n_fail++;
      $display("FAIL reset_div4 actual=%h required=%h", a4, RST);
    end
    n_checks++;
    if (a1 !== RST) begin
      n_fail++;
      $display("FAIL reset_div1 actual=%h required=%h", a1, RST);
    end
    n_checks++;
    if (ad !== RST) begin
      n_fail++;
      $display("FAIL reset_default actual=%h required=%h", ad, RST);
    end
  endtask

  task automatic test_frame();
    clear_stats();
    @(negedge clk);
    rstn = 1'b1;
    run_sb(2 * FRAME4 + 20, 1);
    n_checks++;
    if (fs4_k.size() != 3) begin
      n_fail++;
      $display("FAIL frame_count_div4 actual=%0d required=3", fs4_k.size());
    end else if ((fs4_k[1] - fs4_k[0] != FRAME4) || (fs4_k[2] - fs4_k[1] != FRAME4)) begin
      n_fail++;
      $display("FAIL frame_period_div4 actual=%0d,%0d required=%0d",
               fs4_k[1] - fs4_k[0], fs4_k[2] - fs4_k[1], FRAME4);
    end
    n_checks++;
    if (fs1_k.size() < 2 || fs1_k[1] - fs1_k[0] != FRAME1) begin
      n_fail++;
      $display("FAIL frame_period_div1 actual_count=%0d required_period=%0d",
               fs1_k.size(), FRAME1);
    end
    n_checks++;
    if (ls_in_f != VT) begin
      n_fail++;
      $display("FAIL lines_per_frame actual=%0d required=%0d", ls_in_f, VT);
    end
    n_checks++;
    if (disp_in_f != HV * VV) begin
      n_fail++;
      $display("FAIL display_ticks actual=%0d required=%0d", disp_in_f, HV * VV);
    end
    n_checks++;
    if (vs_low_in_f != VS * HT * 4) begin
      n_fail++;
      $display("FAIL vsync_low_clks actual=%0d required=%0d", vs_low_in_f, VS * HT * 4);
    end
  endtask

  task automatic test_enable_drop();
    obs_t e4, e1;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run_sb(155, 1);
    @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < 51; k++) begin
      q4.push_back((k == 0) ? model(156, 4) : RST);
      q1.push_back((k == 0) ? model(156, 1) : RST);
      @(posedge clk);
      #1;
      e4 = q4.pop_front();
      e1 = q1.pop_front();
      n_checks++;
      if (a4 !== e4) begin
        n_fail++;
        $display("FAIL enable_off_div4 step=%0d actual=%h required=%h", k, a4, e4);
      end
      n_checks++;
      if (a1 !== e1) begin
        n_fail++;
        $display("FAIL enable_off_div1 step=%0d actual=%h required=%h", k, a1, e1);
      end
    end
    @(negedge clk);
    enable = 1'b1;
    clear_stats();
    run_sb(3 * HT * 4, 1);
    n_checks++;
    if (fs4_k.size() == 0 || fs4_k[0] != 5) begin
      n_fail++;
      $display("FAIL reenable_first_frame actual_count=%0d required_k=5", fs4_k.size());
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run_sb(300, 1);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (a4 !== RST) begin
      n_fail++;
      $display("FAIL async_reset_div4 actual=%h required=%h", a4, RST);
    end
    n_checks++;
    if (a1 !== RST) begin
      n_fail++;
      $display("FAIL async_reset_div1 actual=%h required=%h", a1, RST);
    end
    @(negedge clk);
    rstn = 1'b1;
    clear_stats();
    run_sb(FRAME4 + 10, 1);
    n_checks++;
    if (fs4_k.size() != 2 || fs4_k[0] != 5) begin
      n_fail++;
      $display("FAIL restart_div4 actual_count=%0d required_first_k=5", fs4_k.size());
    end
    n_checks++;
    if (fs1_k.size() == 0 || fs1_k[0] != 2) begin
      n_fail++;
      $display("FAIL restart_div1 actual_count=%0d required_first_k=2", fs1_k.size());
    end
  endtask

  task automatic test_default_line();
    int ls_k[$];
    int fs_first, hs_cnt, hs_x, disp_cnt;
    fs_first = -1;
    hs_cnt = 0;
    hs_x = -1;
    disp_cnt = 0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 1; k <= 6420; k++) begin
      @(posedge clk);
      #1;
      if (fsd && fs_first < 0) fs_first = k;
      if (lsd) ls_k.push_back(k);
      if (ls_k.size() == 1) begin
        if (!hsd) begin
          if (hs_x < 0) hs_x = int'(xd);
          hs_cnt++;
        end
        if (dd) disp_cnt++;
      end
    end
    n_checks++;
    if (fs_first != 5) begin
      n_fail++;
      $display("FAIL default_first_frame actual=%0d required=5", fs_first);
    end
    n_checks++;
    if (ls_k.size() < 2 || ls_k[1] - ls_k[0] != 3200) begin
      n_fail++;
      $display("FAIL default_line_period actual_count=%0d required_period=3200", ls_k.size());
    end
    n_checks++;
    if (hs_cnt != 384) begin
      n_fail++;
      $display("FAIL default_hsync_low actual=%0d required=384", hs_cnt);
    end
    n_checks++;
    if (hs_x != 656) begin
      n_fail++;
      $display("FAIL default_hsync_x actual=%0d required=656", hs_x);
    end
    n_checks++;
    if (disp_cnt != 2560) begin
      n_fail++;
      $display("FAIL default_display_clks actual=%0d required=2560", disp_cnt);
    end
  endtask

  initial begin
    rstn = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_frame();
    test_enable_drop();
    test_reset_mid();
    test_default_line();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
